pulse_width_meter: RTL

//  Downstream stage of the averaging pulse generator. Measures the length, in clock periods, of each

---
 rtl/pulse_width_meter_if.sv | 12 +
 rtl/pulse_width_meter.sv | 96 +++++++++
 2 files changed

// File: rtl/pulse_width_meter_if.sv
// Result handshake between the pulse width meter and its consumer:
// active-low data-available, active-high ready-for-data, and the measured width.
interface pulse_width_meter_if #(
    parameter int WIDTH = 16
);
    logic             dav_;
    logic             rfd;
    logic [WIDTH-1:0] result;

    modport master (output dav_, output result, input rfd);
    modport slave  (input dav_, input result, output rfd);
endinterface

// File: rtl/pulse_width_meter.sv
// Counts the clock periods for which pulse_in is high and hands each width to a
// consumer over the dav_/rfd handshake; pulses arriving mid-handshake raise 'lost'.
module pulse_width_meter #(
    parameter int WIDTH = 16
) (
    input  logic                clock,
    input  logic                reset_,
    input  logic                pulse_in,
    pulse_width_meter_if.master xfer,
    output logic                lost
);
    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_COUNT,
        S_WAIT_ACK,
        S_WAIT_RDY
    } state_t;

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    state_t           state, state_next;
    logic [WIDTH-1:0] count, count_next;
    logic [WIDTH-1:0] result_q, result_next;
    logic             dav_q, dav_next;
    logic             lost_q, lost_next;
    logic             pulse_prev;

    // NOTE: every variable gets its hold value first so no path can infer a latch;
    // blocking '=' is correct here because this is pure combinational logic.
    always_comb begin
        state_next  = state;
        count_next  = count;
        result_next = result_q;
        dav_next    = dav_q;
        lost_next   = lost_q;

        case (state)
            S_ARM: begin
                if (!pulse_in) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (pulse_in) begin
                    count_next = {{(WIDTH-1){1'b0}}, 1'b1};
                    state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (pulse_in) begin
                    if (count != COUNT_MAX) count_next = count + 1'b1;
                end else begin
                    result_next = count;
                    dav_next    = 1'b0;
                    state_next  = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!xfer.rfd) begin
                    dav_next   = 1'b1;
                    state_next = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (xfer.rfd) state_next = S_ARM;
            end
            default: state_next = S_ARM;
        endcase

        // A pulse rising while a transfer is outstanding cannot be measured.
        if ((state == S_WAIT_ACK || state == S_WAIT_RDY) && pulse_in && !pulse_prev)
            lost_next = 1'b1;
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update together.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state      <= S_ARM;
            count      <= '0;
            result_q   <= '0;
            dav_q      <= 1'b1;
            lost_q     <= 1'b0;
            pulse_prev <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            result_q   <= result_next;
            dav_q      <= dav_next;
            lost_q     <= lost_next;
            pulse_prev <= pulse_in;
        end
    end

    assign xfer.dav_   = dav_q;
    assign xfer.result = result_q;
    assign lost        = lost_q;
endmodule
